// File: rtl/call_return_stack.sv
// rtl/call_return_stack.sv - return-address stack with overflow/underflow flags, wrap mode and checkpoint/restore
module call_return_stack #(
   parameter int ADDR_W    = 12,
   parameter int DEPTH     = 8,
   parameter int WRAP_MODE = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [ADDR_W-1:0]        push_data,
   input  logic                     checkpoint,
   input  logic                     restore,
   input  logic                     clear_err,
   output logic [ADDR_W-1:0]        top_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PW-1:0]     sp;
   logic [PW-1:0]     sp_m1;
   logic [PW-1:0]     saved_sp;
   logic [CW-1:0]     saved_count;
   logic [ADDR_W-1:0] saved_top;

   logic              wr_en;
   logic [PW-1:0]     wr_addr;
   logic [ADDR_W-1:0] wr_data;
   logic [PW-1:0]     sp_nxt;
   logic [CW-1:0]     count_nxt;
   logic              ovf_evt;
   logic              udf_evt;

   assign sp_m1    = sp - PW'(1);
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign top_data = empty ? '0 : mem[sp_m1];

   // restore overrides push/pop; push+pop on an empty stack falls through to the plain push path
   always_comb begin
      wr_en     = 1'b0;
      wr_addr   = sp;
      wr_data   = push_data;
      sp_nxt    = sp;
      count_nxt = count;
      ovf_evt   = 1'b0;
      udf_evt   = 1'b0;
      if (restore) begin
         sp_nxt    = saved_sp;
         count_nxt = saved_count;
         if (saved_count != '0) begin
            wr_en   = 1'b1;
            wr_addr = saved_sp - PW'(1);
            wr_data = saved_top;
         end
      end else if (push && pop && !empty) begin
         wr_en   = 1'b1;
         wr_addr = sp_m1;
      end else if (push) begin
         if (!full) begin
            wr_en     = 1'b1;
            sp_nxt    = sp + PW'(1);
            count_nxt = count + CW'(1);
         end else begin
            ovf_evt = 1'b1;
            if (WRAP_MODE != 0) begin
               wr_en  = 1'b1;
               sp_nxt = sp + PW'(1);
            end
         end
      end else if (pop) begin
         if (!empty) begin
            sp_nxt    = sp_m1;
            count_nxt = count - CW'(1);
         end else begin
            udf_evt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp          <= '0;
         count       <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         saved_sp    <= '0;
         saved_count <= '0;
         saved_top   <= '0;
      end else begin
         sp        <= sp_nxt;
         count     <= count_nxt;
         overflow  <= ovf_evt | (overflow & ~clear_err);
         underflow <= udf_evt | (underflow & ~clear_err);
         if (checkpoint && !restore) begin
            saved_sp    <= sp;
            saved_count <= count;
            saved_top   <= top_data;
         end
      end
   end

   // storage is intentionally left uninitialised; reset only blocks writes
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_call_return_stack.sv
// tb/tb_call_return_stack.sv - directed bench for call_return_stack, DEPTH=4 with and without wrap mode
module tb_call_return_stack;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic [11:0] push_data = '0;
   logic        checkpoint = 1'b0;
   logic        restore = 1'b0;
   logic        clear_err = 1'b0;

   logic [11:0] top0, top1;
   logic [2:0]  count0, count1;
   logic        empty0, empty1, full0, full1, ovf0, ovf1, udf0, udf1;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   call_return_stack #(.ADDR_W(12), .DEPTH(4), .WRAP_MODE(0)) u_nowrap (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
      .checkpoint(checkpoint), .restore(restore), .clear_err(clear_err),
      .top_data(top0), .count(count0), .empty(empty0), .full(full0),
      .overflow(ovf0), .underflow(udf0)
   );

   call_return_stack #(.ADDR_W(12), .DEPTH(4), .WRAP_MODE(1)) u_wrap (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
      .checkpoint(checkpoint), .restore(restore), .clear_err(clear_err),
      .top_data(top1), .count(count1), .empty(empty1), .full(full1),
      .overflow(ovf1), .underflow(udf1)
   );

   // apply one cycle of stimulus, then release all controls 1ns after the edge
   task automatic cyc(input logic p, input logic q, input logic [11:0] d, input logic ck,
                      input logic rs, input logic ce, input logic rst);
      push = p; pop = q; push_data = d; checkpoint = ck; restore = rs; clear_err = ce; reset = rst;
      @(posedge clk);
      #1;
      push = 0; pop = 0; push_data = '0; checkpoint = 0; restore = 0; clear_err = 0; reset = 0;
   endtask

   task automatic test_reset;
      cyc(1, 0, 12'h123, 0, 0, 0, 1);
      vectors++; if (top0 !== 12'h000) begin $display("FAIL reset_top got %h exp 000", top0); miscompares++; end
      vectors++; if (count0 !== 3'd0) begin $display("FAIL reset_count got %0d exp 0", count0); miscompares++; end
      vectors++; if (empty0 !== 1'b1 || full0 !== 1'b0) begin $display("FAIL reset_empty_full got %b%b exp 10", empty0, full0); miscompares++; end
      vectors++; if (ovf0 !== 1'b0 || udf0 !== 1'b0) begin $display("FAIL reset_flags got %b%b exp 00", ovf0, udf0); miscompares++; end
      vectors++; if (count1 !== 3'd0 || empty1 !== 1'b1) begin $display("FAIL reset_wrap got count %0d empty %b exp 0 1", count1, empty1); miscompares++; end
   endtask

   task automatic test_fill_drain;
      logic [11:0] exp_pop [4];
      exp_pop[0] = 12'h040; exp_pop[1] = 12'h030; exp_pop[2] = 12'h020; exp_pop[3] = 12'h010;
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 12'h010, 0, 0, 0, 0);
      cyc(1, 0, 12'h020, 0, 0, 0, 0);
      cyc(1, 0, 12'h030, 0, 0, 0, 0);
      cyc(1, 0, 12'h040, 0, 0, 0, 0);
      vectors++; if (count0 !== 3'd4 || full0 !== 1'b1) begin $display("FAIL fill_count got %0d full %b exp 4 1", count0, full0); miscompares++; end
      vectors++; if (top0 !== 12'h040) begin $display("FAIL fill_top got %h exp 040", top0); miscompares++; end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (top0 !== exp_pop[i]) begin $display("FAIL drain_top%0d got %h exp %h", i, top0, exp_pop[i]); miscompares++; end
         cyc(0, 1, 0, 0, 0, 0, 0);
      end
      vectors++; if (empty0 !== 1'b1 || top0 !== 12'h000) begin $display("FAIL drain_empty got empty %b top %h exp 1 000", empty0, top0); miscompares++; end
   endtask

   task automatic test_overflow;
      logic [11:0] exp0 [4];
      logic [11:0] exp1 [4];
      exp0[0] = 12'd4; exp0[1] = 12'd3; exp0[2] = 12'd2; exp0[3] = 12'd1;
      exp1[0] = 12'd5; exp1[1] = 12'd4; exp1[2] = 12'd3; exp1[3] = 12'd2;
      cyc(0, 0, 0, 0, 0, 0, 1);
      for (int i = 1; i <= 4; i++) cyc(1, 0, 12'(i), 0, 0, 0, 0);
      cyc(1, 0, 12'd5, 0, 0, 0, 0);
      vectors++; if (count0 !== 3'd4 || top0 !== 12'd4) begin $display("FAIL ovf_nowrap got count %0d top %h exp 4 004", count0, top0); miscompares++; end
      vectors++; if (ovf0 !== 1'b1) begin $display("FAIL ovf_nowrap_flag got %b exp 1", ovf0); miscompares++; end
      vectors++; if (count1 !== 3'd4 || top1 !== 12'd5) begin $display("FAIL ovf_wrap got count %0d top %h exp 4 005", count1, top1); miscompares++; end
      vectors++; if (ovf1 !== 1'b1) begin $display("FAIL ovf_wrap_flag got %b exp 1", ovf1); miscompares++; end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (top0 !== exp0[i]) begin $display("FAIL ovf_pop_nowrap%0d got %h exp %h", i, top0, exp0[i]); miscompares++; end
         vectors++; if (top1 !== exp1[i]) begin $display("FAIL ovf_pop_wrap%0d got %h exp %h", i, top1, exp1[i]); miscompares++; end
         cyc(0, 1, 0, 0, 0, 0, 0);
      end
      vectors++; if (empty0 !== 1'b1 || empty1 !== 1'b1) begin $display("FAIL ovf_drained got %b%b exp 11", empty0, empty1); miscompares++; end
      vectors++; if (ovf0 !== 1'b1) begin $display("FAIL ovf_sticky got %b exp 1", ovf0); miscompares++; end
      cyc(0, 0, 0, 0, 0, 1, 0);
      vectors++; if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin $display("FAIL ovf_clear got %b%b exp 00", ovf0, ovf1); miscompares++; end
   endtask

   task automatic test_underflow;
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 0, 0);
      vectors++; if (udf0 !== 1'b1 || ovf0 !== 1'b0) begin $display("FAIL udf_flag got udf %b ovf %b exp 1 0", udf0, ovf0); miscompares++; end
      vectors++; if (count0 !== 3'd0 || empty0 !== 1'b1) begin $display("FAIL udf_count got %0d exp 0", count0); miscompares++; end
      cyc(0, 1, 0, 0, 0, 1, 0);
      vectors++; if (udf0 !== 1'b1) begin $display("FAIL udf_clear_race got %b exp 1", udf0); miscompares++; end
      cyc(0, 0, 0, 0, 0, 1, 0);
      vectors++; if (udf0 !== 1'b0) begin $display("FAIL udf_clear got %b exp 0", udf0); miscompares++; end
      cyc(1, 0, 12'h077, 0, 0, 0, 0);
      vectors++; if (count0 !== 3'd1 || top0 !== 12'h077) begin $display("FAIL udf_then_push got count %0d top %h exp 1 077", count0, top0); miscompares++; end
   endtask

   task automatic test_replace_restore;
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 12'h100, 0, 0, 0, 0);
      cyc(1, 0, 12'h200, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 1, 12'h2FF, 0, 0, 0, 0);
      vectors++; if (top0 !== 12'h2FF || count0 !== 3'd2) begin $display("FAIL replace got top %h count %0d exp 2ff 2", top0, count0); miscompares++; end
      cyc(1, 0, 12'h300, 0, 0, 0, 0);
      vectors++; if (top0 !== 12'h300 || count0 !== 3'd3) begin $display("FAIL spec_push got top %h count %0d exp 300 3", top0, count0); miscompares++; end
      cyc(1, 1, 12'hBAD, 1, 1, 0, 0);
      vectors++; if (count0 !== 3'd2 || top0 !== 12'h200) begin $display("FAIL restore got count %0d top %h exp 2 200", count0, top0); miscompares++; end
      cyc(0, 1, 0, 0, 0, 0, 0);
      vectors++; if (count0 !== 3'd1 || top0 !== 12'h100) begin $display("FAIL restore_pop got count %0d top %h exp 1 100", count0, top0); miscompares++; end
      cyc(0, 0, 0, 0, 1, 0, 0);
      vectors++; if (count0 !== 3'd2 || top0 !== 12'h200) begin $display("FAIL restore_again got count %0d top %h exp 2 200", count0, top0); miscompares++; end
   endtask

   task automatic test_back_to_back;
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(1, 1, 12'h011, 0, 0, 0, 0);
      vectors++; if (count0 !== 3'd1 || top0 !== 12'h011 || udf0 !== 1'b0) begin $display("FAIL pushpop_empty got count %0d top %h udf %b exp 1 011 0", count0, top0, udf0); miscompares++; end
      cyc(1, 0, 12'h022, 1, 0, 0, 0);
      cyc(1, 0, 12'h033, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      vectors++; if (count0 !== 3'd1 || top0 !== 12'h011) begin $display("FAIL ckpt_same_cycle got count %0d top %h exp 1 011", count0, top0); miscompares++; end
      cyc(1, 0, 12'h022, 0, 0, 0, 0);
      cyc(1, 0, 12'h033, 0, 0, 0, 0);
      cyc(1, 0, 12'h044, 0, 0, 0, 0);
      cyc(1, 1, 12'hABC, 0, 0, 0, 0);
      vectors++; if (count0 !== 3'd4 || top0 !== 12'hABC || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin $display("FAIL replace_full got count %0d top %h ovf %b%b exp 4 abc 00", count0, top0, ovf0, ovf1); miscompares++; end
   endtask

   task automatic test_reset_mid;
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 12'h001, 0, 0, 0, 0);
      cyc(1, 0, 12'h002, 0, 0, 0, 0);
      cyc(1, 0, 12'h003, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(1, 0, 12'h0A1, 0, 0, 0, 0);
      cyc(1, 0, 12'h0A2, 0, 0, 0, 0);
      cyc(1, 0, 12'h0A3, 0, 0, 0, 0);
      vectors++; if (count0 !== 3'd3 || udf0 !== 1'b1) begin $display("FAIL pre_reset got count %0d udf %b exp 3 1", count0, udf0); miscompares++; end
      cyc(1, 0, 12'h555, 0, 0, 0, 1);
      vectors++; if (count0 !== 3'd0 || empty0 !== 1'b1 || top0 !== 12'h000) begin $display("FAIL mid_reset got count %0d empty %b top %h exp 0 1 000", count0, empty0, top0); miscompares++; end
      vectors++; if (ovf0 !== 1'b0 || udf0 !== 1'b0) begin $display("FAIL mid_reset_flags got %b%b exp 00", ovf0, udf0); miscompares++; end
      cyc(0, 0, 0, 0, 1, 0, 0);
      vectors++; if (count0 !== 3'd0 || top0 !== 12'h000) begin $display("FAIL restore_after_reset got count %0d top %h exp 0 000", count0, top0); miscompares++; end
   endtask

   initial begin
      test_reset;
      test_fill_drain;
      test_overflow;
      test_underflow;
      test_replace_restore;
      test_back_to_back;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
